// File: rtl/ipq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ipq_pkg
// Description : Shared types and constants for the instruction prefetch
//               queue: the buffered fetch entry, the canonical NOP encoding
//               and the FIFO occupancy counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package ipq_pkg;

  localparam int IPQ_PC_W  = 32;
  localparam int IPQ_INS_W = 32;
  localparam int IPQ_DEPTH = 4;

  // Counter must hold the value DEPTH itself, hence the extra bit.
  localparam int CNT_W = $clog2(IPQ_DEPTH) + 1;

  // addi x0, x0, 0
  localparam logic [31:0] IPQ_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [IPQ_PC_W-1:0]  pc;
    logic [IPQ_INS_W-1:0] instr;
  } fetch_entry_t;

  function automatic int ipq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_prefetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_prefetch_queue_if
// Description : Bundle of the fetch-side buses around the prefetch queue:
//               memory request/response, IF/ID output handshake and the
//               EX redirect.
//               master : the prefetch queue
//               slave  : the surrounding memory / pipeline / EX stage
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_prefetch_queue_if #(
  parameter int PC_W  = 32,
  parameter int INS_W = 32
) ();

  logic             req_valid;
  logic [PC_W-1:0]  req_addr;
  logic             req_ready;
  logic             resp_valid;
  logic [INS_W-1:0] resp_data;
  logic             out_valid;
  logic [PC_W-1:0]  out_pc;
  logic [INS_W-1:0] out_instr;
  logic             out_ready;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;

  modport master (
    output req_valid, req_addr, out_valid, out_pc, out_instr,
    input  req_ready, resp_valid, resp_data, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr, out_valid, out_pc, out_instr,
    output req_ready, resp_valid, resp_data, out_ready, redirect_valid, redirect_pc
  );

endinterface
`default_nettype wire

// File: rtl/ipq_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ipq_sync_fifo
// Description : Synchronous FIFO of fetch entries with a registered head.
//               flush_i empties the FIFO in one cycle and overrides push/pop.
//               A pop while empty is ignored.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               push_i/push_data_i - write an entry
//               pop_i             - consume the head
//               flush_i           - discard all entries
//               count_o/full_o    - occupancy
//               head_valid_o/head_o - oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module ipq_sync_fifo
  import ipq_pkg::*;
#(
  parameter int  DEPTH   = IPQ_DEPTH,
  parameter type T_ENTRY = fetch_entry_t
) (
  input  wire logic                      clk,
  input  wire logic                      reset,
  input  wire logic                      push_i,
  input  wire T_ENTRY                    push_data_i,
  input  wire logic                      pop_i,
  input  wire logic                      flush_i,
  output      logic [ipq_cnt_w(DEPTH)-1:0] count_o,
  output      logic                      full_o,
  output      logic                      head_valid_o,
  output      T_ENTRY                    head_o
);

  localparam int CW = ipq_cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);

  T_ENTRY          mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            w_do_push;
  logic            w_do_pop;

  assign full_o       = (count_q == CW'(DEPTH));
  assign head_valid_o = (count_q != '0);
  assign count_o      = count_q;
  assign head_o       = mem_q[rd_ptr_q];

  // When full, a simultaneous pop frees the slot being written.
  assign w_do_pop  = pop_i && head_valid_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (w_do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (w_do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_prefetch_queue
// Description : Fetch front end. Owns the fetch PC, issues in-order word
//               requests to a variable-latency instruction memory, buffers
//               returned words with their PCs and presents them to IF/ID.
//               A redirect flushes the queue and marks every in-flight
//               request as stale so its response is discarded.
// Ports       : clk, reset - clock, synchronous active-high reset
//               bus        - instr_prefetch_queue_if.master (request,
//                            response, IF/ID output, redirect)
// Config      : IPQ_BYPASS_EN - when defined, a response arriving at an
//               empty queue is presented to IF/ID in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_prefetch_queue
  import ipq_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INS_W    = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input wire logic               clk,
  input wire logic               reset,
  instr_prefetch_queue_if.master bus
);

  localparam int CW = ipq_cnt_w(DEPTH);
  // In-flight counters need headroom beyond DEPTH: after a redirect the
  // stale requests still occupy the memory while new ones are issued.
  localparam int OW = CW + 3;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] resp_pc_q,  resp_pc_d;
  logic [OW-1:0]   outst_q,    outst_d;
  logic [OW-1:0]   stale_q,    stale_d;
  logic            active_q;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_valid;
  entry_t          fifo_head;
  entry_t          w_push_entry;

  logic [OW-1:0]   w_credit;
  logic            w_issue;
  logic            w_resp_live;
  logic            w_push;
  logic            w_pop;

  // Credit counts buffered plus live in-flight words; stale ones will never
  // land in the FIFO, so they do not consume space.
  assign w_credit = OW'(fifo_count) + (outst_q - stale_q);

  // active_q keeps the request bus quiet for the first cycle out of reset.
  assign bus.req_valid = active_q && !bus.redirect_valid && (w_credit < OW'(DEPTH));
  assign bus.req_addr  = fetch_pc_q;
  assign w_issue       = bus.req_valid && bus.req_ready;

  assign w_resp_live  = bus.resp_valid && (stale_q == '0) && !bus.redirect_valid;
  assign w_push_entry = '{pc: resp_pc_q, instr: bus.resp_data};
  assign w_pop        = fifo_valid && bus.out_ready && !bus.redirect_valid;

`ifdef IPQ_BYPASS_EN
  logic w_bypass;
  assign w_bypass      = w_resp_live && !fifo_valid;
  // A bypassed word consumed this cycle never needs a FIFO slot.
  assign w_push        = w_resp_live && !(w_bypass && bus.out_ready);
  assign bus.out_valid = fifo_valid || w_bypass;
  assign bus.out_pc    = w_bypass ? resp_pc_q     : fifo_head.pc;
  assign bus.out_instr = w_bypass ? bus.resp_data : fifo_head.instr;
`else
  assign w_push        = w_resp_live;
  assign bus.out_valid = fifo_valid;
  assign bus.out_pc    = fifo_head.pc;
  assign bus.out_instr = fifo_head.instr;
`endif

  ipq_sync_fifo #(
    .DEPTH   (DEPTH),
    .T_ENTRY (entry_t)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (w_push),
    .push_data_i  (w_push_entry),
    .pop_i        (w_pop),
    .flush_i      (bus.redirect_valid),
    .count_o      (fifo_count),
    .full_o       (fifo_full),
    .head_valid_o (fifo_valid),
    .head_o       (fifo_head)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    stale_d    = stale_q;
    if (bus.redirect_valid) begin
      // No issue this cycle; whatever is still in flight after this
      // cycle's response belongs to the abandoned path.
      fetch_pc_d = bus.redirect_pc;
      resp_pc_d  = bus.redirect_pc;
      outst_d    = outst_q - OW'(bus.resp_valid);
      stale_d    = outst_q - OW'(bus.resp_valid);
    end else begin
      if (w_issue)     fetch_pc_d = fetch_pc_q + PC_W'(4);
      if (w_resp_live) resp_pc_d  = resp_pc_q + PC_W'(4);
      if (bus.resp_valid && (stale_q != '0)) stale_d = stale_q - 1'b1;
      outst_d = outst_q + OW'(w_issue) - OW'(bus.resp_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      stale_q    <= '0;
      active_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      stale_q    <= stale_d;
      active_q   <= 1'b1;
    end
  end

  // The credit rule must make a push into a full FIFO impossible.
  ap_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_push && fifo_full && !w_pop));

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_prefetch_queue
// Description : Directed bench for instr_prefetch_queue with a fixed-latency
//               in-order memory model whose word at address a is
//               a ^ 32'hC0DE_0000.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch_queue;

  localparam int PC_W  = 32;
  localparam int INS_W = 32;
  localparam int DEPTH = 4;
`ifdef IPQ_BYPASS_EN
  localparam logic [31:0] BYP = 32'd1;
`else
  localparam logic [31:0] BYP = 32'd0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_prefetch_queue_if #(.PC_W(PC_W), .INS_W(INS_W)) bus_if ();

  instr_prefetch_queue #(
    .PC_W     (PC_W),
    .INS_W    (INS_W),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;
  int cycn     = 0;
  int ret_cnt  = 0;
  int pop_cnt  = 0;
  int max_occ  = 0;
  int ov_cnt   = 0;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_ins[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] got_pc_at(input int i);
    if (i < got_pc.size()) return got_pc[i];
    return 32'hBAD0_BAD0;
  endfunction

  function automatic logic [31:0] got_ins_at(input int i);
    if (i < got_ins.size()) return got_ins[i];
    return 32'hBAD0_BAD0;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, expv);
    end
  endtask

  // One clock cycle: sample at the falling edge, advance the memory model
  // just after the rising edge and drive this cycle's response.
  task automatic cyc();
    logic        acc;
    logic        rst_s;
    logic [31:0] acc_a;
    int          occ;
    @(negedge clk);
    acc   = bus_if.req_valid && bus_if.req_ready;
    acc_a = bus_if.req_addr;
    rst_s = reset;
    occ   = mq_addr.size() + ret_cnt - pop_cnt;
    if (occ > max_occ) max_occ = occ;
    if (bus_if.out_valid === 1'b1) ov_cnt++;
    if (!rst_s && bus_if.out_valid && bus_if.out_ready && !bus_if.redirect_valid) begin
      got_pc.push_back(bus_if.out_pc);
      got_ins.push_back(bus_if.out_instr);
      pop_cnt++;
    end
    if (!rst_s && bus_if.resp_valid) ret_cnt++;
    @(posedge clk);
    #1;
    cycn++;
    if (bus_if.resp_valid && mq_addr.size() > 0) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (rst_s) begin
      mq_addr.delete();
      mq_due.delete();
      ret_cnt = 0;
      pop_cnt = 0;
    end else if (acc === 1'b1) begin
      mq_addr.push_back(acc_a);
      mq_due.push_back(cycn + lat - 1);
    end
    if (mq_addr.size() > 0 && mq_due[0] == cycn) begin
      bus_if.resp_valid = 1'b1;
      bus_if.resp_data  = memf(mq_addr[0]);
    end else begin
      bus_if.resp_valid = 1'b0;
      bus_if.resp_data  = '0;
    end
  endtask

  // Leaves the bench in the first cycle after reset release.
  task automatic do_reset(input int l);
    lat                   = l;
    reset                 = 1'b1;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = '0;
    bus_if.req_ready      = 1'b1;
    bus_if.out_ready      = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    got_pc.delete();
    got_ins.delete();
    max_occ = 0;
    ov_cnt  = 0;
  endtask

  initial begin
    int n2xx;
    reset                 = 1'b1;
    bus_if.req_ready      = 1'b1;
    bus_if.resp_valid     = 1'b0;
    bus_if.resp_data      = '0;
    bus_if.out_ready      = 1'b1;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = '0;

    // Reset state and streaming at latency 1.
    do_reset(1);
    #1;
    check("rst_req_valid", {31'd0, bus_if.req_valid}, 32'd0);
    check("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("rst_out_pc",    bus_if.out_pc,    32'd0);
    check("rst_out_instr", bus_if.out_instr, 32'd0);
    cyc(); #1;
    check("t1_req_valid", {31'd0, bus_if.req_valid}, 32'd1);
    check("t1_req_addr",  bus_if.req_addr, 32'd0);
    cyc(); #1;
    check("t1_first_resp_out_valid", {31'd0, bus_if.out_valid}, BYP);
    repeat (6) cyc();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_pc%0d", i),  got_pc_at(i),  32'(4 * i));
      check($sformatf("t1_ins%0d", i), got_ins_at(i), memf(32'(4 * i)));
    end

    // Back-pressure at latency 2: queue fills to DEPTH then drains in order.
    do_reset(2);
    bus_if.out_ready = 1'b0;
    repeat (10) cyc();
    #1;
    check("t2_req_stalled", {31'd0, bus_if.req_valid}, 32'd0);
    check("t2_head_valid",  {31'd0, bus_if.out_valid}, 32'd1);
    check("t2_head_pc",     bus_if.out_pc, 32'd0);
    check("t2_max_occupancy", 32'(max_occ), 32'd4);
    bus_if.out_ready = 1'b1;
    repeat (6) cyc();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_pc%0d", i),  got_pc_at(i),  32'(4 * i));
      check($sformatf("t2_ins%0d", i), got_ins_at(i), memf(32'(4 * i)));
    end

    // Redirect at latency 3 with three requests in flight.
    do_reset(3);
    repeat (4) cyc();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h100;
    #1;
    check("t3_no_issue_on_redirect", {31'd0, bus_if.req_valid}, 32'd0);
    cyc();
    bus_if.redirect_valid = 1'b0;
    got_pc.delete();
    got_ins.delete();
    ov_cnt = 0;
    #1;
    check("t3_new_req_valid", {31'd0, bus_if.req_valid}, 32'd1);
    check("t3_new_req_addr",  bus_if.req_addr, 32'h100);
    repeat (3) cyc();
    check("t3_stale_never_valid", 32'(ov_cnt), 32'd0);
    #1;
    check("t3_out_valid_c8", {31'd0, bus_if.out_valid}, BYP);
    cyc(); #1;
    check("t3_out_valid_c9", {31'd0, bus_if.out_valid}, 32'd1);
    repeat (4) cyc();
    check("t3_pc0",  got_pc_at(0),  32'h100);
    check("t3_ins0", got_ins_at(0), memf(32'h100));
    check("t3_pc1",  got_pc_at(1),  32'h104);
    check("t3_ins1", got_ins_at(1), memf(32'h104));

    // Redirect coinciding with a response and a pop.
    do_reset(1);
    repeat (5) cyc();
    #1;
    check("t4_head_before", {31'd0, bus_if.out_valid}, 32'd1);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h40;
    cyc();
    bus_if.redirect_valid = 1'b0;
    got_pc.delete();
    got_ins.delete();
    #1;
    check("t4_flushed", {31'd0, bus_if.out_valid}, 32'd0);
    check("t4_req_addr", bus_if.req_addr, 32'h40);
    repeat (4) cyc();
    check("t4_pc0",  got_pc_at(0),  32'h40);
    check("t4_ins0", got_ins_at(0), memf(32'h40));
    check("t4_pc1",  got_pc_at(1),  32'h44);

    // Back-to-back redirects, then a fetch PC wrap.
    do_reset(2);
    repeat (4) cyc();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h200;
    cyc();
    bus_if.redirect_pc    = 32'h300;
    cyc();
    bus_if.redirect_valid = 1'b0;
    got_pc.delete();
    got_ins.delete();
    #1;
    check("t5_req_valid", {31'd0, bus_if.req_valid}, 32'd1);
    check("t5_req_addr",  bus_if.req_addr, 32'h300);
    repeat (8) cyc();
    check("t5_pc0",  got_pc_at(0),  32'h300);
    check("t5_ins0", got_ins_at(0), memf(32'h300));
    check("t5_pc1",  got_pc_at(1),  32'h304);
    n2xx = 0;
    foreach (got_pc[i]) if (got_pc[i][31:8] == 24'h2) n2xx++;
    check("t5_no_0x2xx_delivered", 32'(n2xx), 32'd0);

    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'hFFFF_FFFC;
    cyc();
    bus_if.redirect_valid = 1'b0;
    got_pc.delete();
    got_ins.delete();
    #1;
    check("t5_wrap_addr0", bus_if.req_addr, 32'hFFFF_FFFC);
    cyc(); #1;
    check("t5_wrap_addr1", bus_if.req_addr, 32'h0);
    repeat (6) cyc();
    check("t5_wrap_pc0",  got_pc_at(0),  32'hFFFF_FFFC);
    check("t5_wrap_ins0", got_ins_at(0), memf(32'hFFFF_FFFC));
    check("t5_wrap_pc1",  got_pc_at(1),  32'h0);
    check("t5_wrap_ins1", got_ins_at(1), memf(32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
